// File: rtl/ahb_slave_mux_7.sv
// ahb_slave_mux_7: AHB master-to-slave-7 address/data multiplexer with data-phase tracking.
module ahb_slave_mux_7 #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                                 hclk,
  input  logic                                 hreset,
  input  logic [MASTER_NUM-1:0]                hgrant,
  input  logic                                 hsel,
  input  logic [MASTER_NUM-1:0][ADDR_W-1:0]    m_haddr,
  input  logic [MASTER_NUM-1:0][1:0]           m_htrans,
  input  logic [MASTER_NUM-1:0]                m_hwrite,
  input  logic [MASTER_NUM-1:0][2:0]           m_hsize,
  input  logic [MASTER_NUM-1:0][2:0]           m_hburst,
  input  logic [MASTER_NUM-1:0][DATA_W-1:0]    m_hwdata,
  output logic [ADDR_W-1:0]                    s_haddr,
  output logic [1:0]                           s_htrans,
  output logic                                 s_hwrite,
  output logic [2:0]                           s_hsize,
  output logic [2:0]                           s_hburst,
  output logic [DATA_W-1:0]                    s_hwdata,
  output logic                                 s_hsel,
  input  logic                                 s_hready,
  input  logic                                 s_hresp,
  input  logic [DATA_W-1:0]                    s_hrdata,
  output logic [MASTER_NUM-1:0]                m_hready,
  output logic [MASTER_NUM-1:0]                m_hresp,
  output logic [DATA_W-1:0]                    m_hrdata,
  output logic                                 hwait,
  output logic                                 onehot_err
);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR} state_t;
  state_t state;
  logic [MASTER_NUM-1:0] aph_own, dph_own, sel;
  logic multi, onehot;
  assign multi = |(hgrant & (hgrant - MASTER_NUM'(1)));
  assign onehot = |hgrant && !multi;
  // During slave wait the arbiter drops hgrant, so the registered owner keeps the address stable
  assign sel = onehot ? hgrant : (hsel && !multi) ? aph_own : '0;
  assign s_hsel = |sel;
  assign m_hrdata = s_hrdata;
  assign hwait = (state != S_IDLE) && !s_hready;
  always_comb begin
    s_haddr = '0;
    s_htrans = 2'd0;
    s_hwrite = 1'b0;
    s_hsize = 3'd0;
    s_hburst = 3'd0;
    s_hwdata = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (sel[i]) begin
        s_haddr = m_haddr[i];
        s_htrans = m_htrans[i];
        s_hwrite = m_hwrite[i];
        s_hsize = m_hsize[i];
        s_hburst = m_hburst[i];
      end
      if (dph_own[i]) s_hwdata = m_hwdata[i];
      m_hready[i] = (dph_own[i] || sel[i]) ? s_hready : (state == S_IDLE);
      m_hresp[i] = dph_own[i] ? s_hresp : 1'b0;
    end
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= S_IDLE;
      aph_own <= '0;
      dph_own <= '0;
      onehot_err <= 1'b0;
    end else begin
      if (multi) onehot_err <= 1'b1;
      aph_own <= onehot ? hgrant : hsel ? aph_own : '0;
      case (state)
        S_IDLE, S_DATA: begin
          if (s_hready) begin
            state <= s_htrans[1] ? S_DATA : S_IDLE;
            dph_own <= s_htrans[1] ? sel : '0;
          end else if (state == S_DATA && s_hresp) state <= S_ERR;
        end
        S_ERR: begin
          if (s_hready) begin
            state <= S_IDLE;
            dph_own <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ahb_slave_mux_7.md
AHB_SLAVE_MUX_7 -- requirements
Module: ahb_slave_mux_7

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 2, number of masters competing for slave 7.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have port hclk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port hreset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port hgrant, input, MASTER_NUM, one-hot grant from the slave 7 arbiter; forced to 0 during slave wait.
REQ-007 SHALL have port hsel, input, 1, arbiter "some master granted" flag; stays high through wait states.
REQ-008 SHALL have port m_haddr, input, MASTER_NUM x ADDR_W, per-master address.
REQ-009 SHALL have port m_htrans, input, MASTER_NUM x 2, per-master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-010 SHALL have ports m_hwrite (MASTER_NUM x 1), m_hsize (MASTER_NUM x 3) and m_hburst (MASTER_NUM x hburst_type), all inputs, per-master control.
REQ-011 SHALL have port m_hwdata, input, MASTER_NUM x DATA_W, per-master write data.
REQ-012 SHALL have ports s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst and s_hwdata, all outputs to slave 7, with widths matching the per-master inputs.
REQ-013 SHALL have port s_hsel, output, 1, slave select.
REQ-014 SHALL have ports s_hready (input, 1), s_hresp (input, 1, 0=OKAY 1=ERROR) and s_hrdata (input, DATA_W), the slave response.
REQ-015 SHALL have ports m_hready (MASTER_NUM), m_hresp (MASTER_NUM) and m_hrdata (DATA_W), all outputs, the response to the masters.
REQ-016 SHALL have port hwait, output, 1, wait indication fed back to the arbiter hwait input.
REQ-017 SHALL have port onehot_err, output, 1, sticky flag: hgrant seen with more than one bit set.

Function
REQ-018 SHALL hold the address-phase owner register aph_own (MASTER_NUM bits); it loads hgrant whenever hgrant is exactly one-hot, clears when hsel=0, and holds otherwise.
REQ-019 SHALL select the address mux from hgrant when hgrant is one-hot, otherwise from aph_own when hsel=1, otherwise select nothing.
REQ-020 SHALL drive s_htrans=IDLE, s_hsel=0 and s_haddr/control=0 when nothing is selected; otherwise s_hsel=1 and the selected master's address and control combinationally.
REQ-021 SHALL treat hgrant with popcount>1 as no selection, set onehot_err=1 on the next edge, and clear onehot_err only by reset.
REQ-022 SHALL implement FSM IDLE/DATA/ERR: IDLE means no data phase; DATA means a data phase is pending; ERR is the second cycle of a two-cycle ERROR.
REQ-023 SHALL, from IDLE or DATA with s_hready=1, load the data-phase owner register dph_own with the selected owner and go to DATA when the selected s_htrans is NONSEQ or SEQ, and otherwise go to IDLE with dph_own=0.
REQ-024 SHALL stay in DATA when s_hready=0 and s_hresp=OKAY, holding dph_own.
REQ-025 SHALL go from DATA to ERR when s_hready=0 and s_hresp=ERROR.
REQ-026 SHALL leave ERR only on s_hready=1: to IDLE with dph_own=0, discarding the overlapping address phase of the errored master.
REQ-027 SHALL mux s_hwdata from dph_own and drive 0 when dph_own=0.
REQ-028 SHALL broadcast s_hrdata unchanged on m_hrdata.
REQ-029 SHALL drive m_hready[i]=s_hready when dph_own[i]=1 or master i is selected; otherwise m_hready[i]=1 when in IDLE and 0 in DATA/ERR.
REQ-030 SHALL drive m_hresp[i]=s_hresp when dph_own[i]=1, otherwise OKAY.
REQ-031 SHALL drive hwait = ~s_hready in DATA or ERR, and 0 in IDLE.
REQ-032 SHALL allow a grant change on a s_hready=1 edge: the new owner's address is pipelined while the old owner completes its data phase, with zero bubble cycles.

Reset
REQ-033 SHALL, when hreset=1 at a rising edge, force FSM=IDLE, aph_own=0, dph_own=0 and onehot_err=0, overriding any in-flight transfer, including mid-wait or mid-ERR.
REQ-034 SHALL produce these outputs while in reset state with hgrant=0: s_hsel=0, s_htrans=IDLE, s_hwdata=0, hwait=0, m_hresp=all OKAY.

Verification
REQ-035 Single write: hgrant=01, m0 NONSEQ addr 0x70, s_hready=1 -> s_haddr=0x70 same cycle, next cycle DATA with s_hwdata=m_hwdata[0], m_hready[0]=1.
REQ-036 Wait hold: in DATA, s_hready=0 for 3 cycles and the arbiter drops hgrant to 00 with hsel=1 -> s_haddr holds m0's address, hwait=1 for 3 cycles, dph_own stays 01.
REQ-037 Handover: m0 SEQ last beat in data phase, hgrant 01->10 with s_hready=1 -> same cycle s_hwdata from m0 and s_haddr from m1; next cycle dph_own=10.
REQ-038 Error: s_hresp=1 with s_hready=0, then s_hresp=1 with s_hready=1 -> FSM DATA->ERR->IDLE, m_hresp[0]=1 both cycles, m_hresp[1]=0, dph_own=0 afterwards.
REQ-039 Illegal grant: hgrant=11 -> s_hsel=0, s_htrans=IDLE, onehot_err=1 next cycle and held after hgrant returns to 01.
REQ-040 Reset mid-wait: hreset=1 while in DATA with s_hready=0 -> next cycle FSM=IDLE, hwait=0, s_hwdata=0.
